// File: rtl/gf16_op_seq.sv
// gf16_op_seq: sequencer around a single combinational GF(2^4) multiplier
// (field polynomial x^4 + x + 1). Executes MUL, SQR, INV or DIV on 4-bit
// operands, one multiply per cycle. INV uses x^-1 = x^14 built from a short
// square/multiply chain; DIV is a * b^-1.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous reset, active low
//   in_valid_i   request valid
//   in_ready_o   request accepted when in_valid_i & in_ready_o (high only in idle)
//   in_op_i      00 MUL a*b, 01 SQR a*a, 10 INV a^-1, 11 DIV a*b^-1
//   in_a_i       operand a
//   in_b_i       operand b (MUL and DIV only)
//   in_tag_i     user tag, echoed on the result
//   out_valid_o  result valid, held until out_ready_i
//   out_ready_i  consumer ready
//   out_res_o    result
//   out_dz_o     DIV by zero (out_res_o forced to 0)
//   out_tag_o    tag of this result
module gf16_op_seq #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       in_op_i,
    input  logic [3:0]       in_a_i,
    input  logic [3:0]       in_b_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [3:0]       out_res_o,
    output logic             out_dz_o,
    output logic [TAG_W-1:0] out_tag_o
);

    localparam logic [1:0] OpMul = 2'b00;
    localparam logic [1:0] OpSqr = 2'b01;
    localparam logic [1:0] OpInv = 2'b10;
    localparam logic [1:0] OpDiv = 2'b11;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    // Carry-less 4x4 product reduced with x^4 = x + 1.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                p[i+j] = p[i+j] ^ (a[i] & b[j]);
            end
        end
        gf_mul = {p[3] ^ p[6],
                  p[2] ^ p[5] ^ p[6],
                  p[1] ^ p[4] ^ p[5],
                  p[0] ^ p[4]};
    endfunction

    state_e           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [3:0]       sq_q, sq_d;
    logic [3:0]       pr_q, pr_d;
    logic [3:0]       res_q, res_d;
    logic             dz_q, dz_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic [3:0] x_op;
    logic [3:0] mul_a, mul_b, prod;

    // Value being inverted: the divisor for DIV, otherwise a.
    assign x_op = (op_q == OpDiv) ? b_q : a_q;

    // Multiplier operand selection by op and step.
    always_comb begin
        mul_a = a_q;
        mul_b = b_q;
        unique case (op_q)
            OpMul: begin
                mul_a = a_q;
                mul_b = b_q;
            end
            OpSqr: begin
                mul_a = a_q;
                mul_b = a_q;
            end
            default: begin
                case (step_q)
                    3'd0:    begin mul_a = x_op; mul_b = x_op; end  // x^2
                    3'd1:    begin mul_a = sq_q; mul_b = sq_q; end  // x^4
                    3'd2:    begin mul_a = pr_q; mul_b = sq_q; end  // x^6
                    3'd3:    begin mul_a = sq_q; mul_b = sq_q; end  // x^8
                    3'd4:    begin mul_a = pr_q; mul_b = sq_q; end  // x^14
                    default: begin mul_a = a_q;  mul_b = pr_q; end  // a * x^-1
                endcase
            end
        endcase
    end

    assign prod = gf_mul(mul_a, mul_b);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        sq_d      = sq_q;
        pr_d      = pr_q;
        res_d     = res_q;
        dz_d      = dz_q;
        out_tag_d = out_tag_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    op_d    = in_op_i;
                    a_d     = in_a_i;
                    b_d     = in_b_i;
                    tag_d   = in_tag_i;
                    step_d  = 3'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                step_d = step_q + 3'd1;
                if (op_q == OpMul || op_q == OpSqr) begin
                    res_d     = prod;
                    dz_d      = 1'b0;
                    out_tag_d = tag_q;
                    state_d   = StDone;
                end else begin
                    case (step_q)
                        3'd0: begin
                            sq_d = prod;
                            pr_d = prod;
                        end
                        3'd1: sq_d = prod;
                        3'd2: pr_d = prod;
                        3'd3: sq_d = prod;
                        3'd4: begin
                            pr_d = prod;
                            if (op_q == OpInv) begin
                                res_d     = prod;
                                dz_d      = 1'b0;
                                out_tag_d = tag_q;
                                state_d   = StDone;
                            end
                        end
                        default: begin
                            dz_d      = (b_q == 4'd0);
                            res_d     = (b_q == 4'd0) ? 4'd0 : prod;
                            out_tag_d = tag_q;
                            state_d   = StDone;
                        end
                    endcase
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            step_q    <= 3'd0;
            op_q      <= 2'b00;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            tag_q     <= '0;
            sq_q      <= 4'd0;
            pr_q      <= 4'd0;
            res_q     <= 4'd0;
            dz_q      <= 1'b0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            sq_q      <= sq_d;
            pr_q      <= pr_d;
            res_q     <= res_d;
            dz_q      <= dz_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign out_res_o   = res_q;
    assign out_dz_o    = dz_q;
    assign out_tag_o   = out_tag_q;

endmodule

// File: tb/tb_gf16_op_seq.sv
// Self-checking bench for gf16_op_seq: a transaction-level reference model
// (results from polynomial arithmetic, latency as a countdown) is compared
// with the DUT every cycle, alongside directed literal checks.
module tb_gf16_op_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_a, in_b, in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_res;
    logic       out_dz;
    logic [3:0] out_tag;

    int checks = 0;
    int errors = 0;

    gf16_op_seq #(.TAG_W(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_op_i    (in_op),
        .in_a_i     (in_a),
        .in_b_i     (in_b),
        .in_tag_i   (in_tag),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_res_o  (out_res),
        .out_dz_o   (out_dz),
        .out_tag_o  (out_tag)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: shift-and-add with reduction by x^4 + x + 1.
    function automatic int ref_mul(input int a, input int b);
        int r, aa;
        r  = 0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (((b >> i) & 1) != 0) r = r ^ aa;
            aa = aa << 1;
            if ((aa & 16) != 0) aa = aa ^ 19;
        end
        return r;
    endfunction

    // Inverse by exhaustive search; 0 maps to 0.
    function automatic int ref_inv(input int a);
        for (int c = 1; c < 16; c++) if (ref_mul(a, c) == 1) return c;
        return 0;
    endfunction

    function automatic int ref_len(input int op);
        case (op)
            0, 1:    return 1;
            2:       return 5;
            default: return 6;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: m_cnt counts remaining multiplies of an accepted op.
    bit started = 0;
    int m_cnt = 0;
    bit m_valid = 0;
    int m_res = 0, m_dz = 0, m_tag = 0;
    int p_res, p_dz, p_tag;
    int tag_q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            started = 1;
            m_cnt   = 0;
            m_valid = 0;
            m_res   = 0;
            m_dz    = 0;
            m_tag   = 0;
            tag_q.delete();
        end else if (m_valid) begin
            if (out_ready) m_valid = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1;
                m_res   = p_res;
                m_dz    = p_dz;
                m_tag   = tag_q.pop_front();
            end
        end else if (in_valid) begin
            p_dz = 0;
            case (in_op)
                2'b00: p_res = ref_mul(in_a, in_b);
                2'b01: p_res = ref_mul(in_a, in_a);
                2'b10: p_res = ref_inv(in_a);
                default: begin
                    p_res = (in_b == 0) ? 0 : ref_mul(in_a, ref_inv(in_b));
                    p_dz  = (in_b == 0) ? 1 : 0;
                end
            endcase
            tag_q.push_back(int'(in_tag));
            m_cnt = ref_len(in_op);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started && rst_n) begin
            check("in_ready", in_ready, (!m_valid && m_cnt == 0) ? 1 : 0);
            check("out_valid", out_valid, m_valid ? 1 : 0);
            if (m_valid) begin
                check("out_res", out_res, m_res);
                check("out_dz", out_dz, m_dz);
                check("out_tag", out_tag, m_tag);
            end
        end
    end

    // Directed op: issue from idle, measure latency, check, then pop.
    task automatic run_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] tag, input int exp_res, input int exp_dz,
                          input int exp_lat);
        int lat;
        @(posedge clk); #1;
        in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("res", out_res, exp_res);
        check("dz", out_dz, exp_dz);
        check("tag", out_tag, tag);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    initial begin
        int hold_res;
        rst_n = 0; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 0;

        // Pin the model with hand-computed values.
        check("model_mul_3_7", ref_mul(3, 7), 9);
        check("model_inv_2", ref_inv(2), 9);
        check("model_sqr_8", ref_mul(8, 8), 12);

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_res", out_res, 0);
        check("rst_out_dz", out_dz, 0);
        check("rst_out_tag", out_tag, 0);
        rst_n = 1;

        run_op(2'b00, 4'd3, 4'd7, 4'hA, 9, 0, 1);
        run_op(2'b10, 4'd2, 4'd0, 4'h3, 9, 0, 5);
        run_op(2'b10, 4'd0, 4'd0, 4'h4, 0, 0, 5);
        run_op(2'b01, 4'd8, 4'd0, 4'h5, 12, 0, 1);
        run_op(2'b11, 4'd1, 4'd2, 4'h6, 9, 0, 6);
        run_op(2'b11, 4'd5, 4'd0, 4'h7, 0, 1, 6);

        // INV sweep: a * a^-1 must be 1.
        for (int a = 1; a < 16; a++) begin
            run_op(2'b10, 4'(a), 4'd0, 4'(a), ref_inv(a), 0, 5);
            check("inv_product", ref_mul(a, int'(out_res)), 1);
        end

        // Backpressure: result held, new request refused while not popped.
        @(posedge clk); #1;
        in_valid = 1; in_op = 2'b00; in_a = 4'd6; in_b = 4'd5; in_tag = 4'hB;
        @(posedge clk); #1;
        in_op = 2'b01; in_a = 4'd9; in_tag = 4'hC;
        repeat (1) @(posedge clk);
        #1;
        hold_res = int'(out_res);
        check("bp_valid0", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1);
            check("bp_res", out_res, hold_res);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check("bp_idle_after_pop", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        check("bp_second_accepted", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_second_res", out_res, ref_mul(9, 9));
        check("bp_second_tag", out_tag, 4'hC);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;

        // Reset during step 3 of an INV.
        @(posedge clk); #1;
        in_valid = 1; in_op = 2'b10; in_a = 4'd7; in_tag = 4'hD;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_ready", in_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        check("rst_mid_no_result", out_valid, 0);
        run_op(2'b11, 4'd7, 4'd3, 4'hE, ref_mul(7, ref_inv(3)), 0, 6);

        // Random back-to-back traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_a      = 4'($urandom_range(0, 15));
            in_b      = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            in_tag    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        in_valid = 0;
        out_ready = 1;
        repeat (10) @(posedge clk);
        #1;
        check("drained", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
